// File: rtl/serial_fifo_pkg.sv
// Shared defaults and the status bundle the register block reads from serial_fifo.
package serial_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 9;
  localparam int unsigned DEF_ADDR_WIDTH = 4;

  // Snapshot of FIFO state at the default geometry, packed for the AXI status block.
  typedef struct packed {
    logic                      overflow;
    logic                      underflow;
    logic                      almost_full;
    logic                      almost_empty;
    logic                      full;
    logic                      empty;
    logic [DEF_ADDR_WIDTH:0]   count;
    logic [DEF_ADDR_WIDTH:0]   peak_count;
  } fifo_status_t;

endpackage

// File: rtl/serial_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset (LUTRAM-friendly).
module serial_fifo_ram
  import serial_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: one entry per clock when enabled.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/serial_fifo.sv
// Synchronous FIFO with wrap-bit pointers, sticky error flags, thresholds and peak-fill tracking.
module serial_fifo
  import serial_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_request,
  input  logic                  rd_request,
  input  logic                  clear_flags_request,
  input  logic [ADDR_WIDTH:0]   afull_threshold,
  input  logic [ADDR_WIDTH:0]   aempty_threshold,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   wr_index,
  output logic [ADDR_WIDTH:0]   rd_index,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   peak_count
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] peak_q, peak_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [PTR_W-1:0] next_count;
  logic             wr_accept;
  logic             rd_accept;
  logic             empty_c;
  logic             full_c;
  logic [PTR_W-1:0] count_c;

  // Status derived from the registered pointers, so it never lags them.
  always_comb begin
    count_c = wr_ptr_q - rd_ptr_q;
    empty_c = (wr_ptr_q == rd_ptr_q);
    full_c  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
              (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  end

  // Next-state: pointers, sticky flags (set beats clear) and high-water mark.
  always_comb begin
    wr_accept  = 1'b0;
    rd_accept  = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    peak_d     = peak_q;
    next_count = '0;

    wr_accept = wr_request && !full_c;
    rd_accept = rd_request && !empty_c;

    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    ovf_d = (wr_request && full_c)  || (ovf_q && !clear_flags_request);
    udf_d = (rd_request && empty_c) || (udf_q && !clear_flags_request);

    next_count = wr_ptr_d - rd_ptr_d;
    if (clear_flags_request || (next_count > peak_q)) begin
      peak_d = next_count;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      peak_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      peak_q   <= peak_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage; a write arriving in the reset cycle is dropped.
  serial_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_accept && reset),
    .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (rd_data)
  );

  assign empty        = empty_c;
  assign full         = full_c;
  assign count        = count_c;
  assign almost_full  = (count_c >= afull_threshold);
  assign almost_empty = (count_c <= aempty_threshold);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign wr_index     = wr_ptr_q;
  assign rd_index     = rd_ptr_q;
  assign peak_count   = peak_q;

endmodule

// File: tb/tb_serial_fifo.sv
// Directed bench for serial_fifo at default geometry (9-bit data, 16 entries).
module tb_serial_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] wr_data;
  logic       wr_request;
  logic       rd_request;
  logic       clear_flags_request;
  logic [4:0] afull_threshold;
  logic [4:0] aempty_threshold;
  logic [8:0] rd_data;
  logic       empty, full, almost_full, almost_empty, overflow, underflow;
  logic [4:0] wr_index, rd_index, count, peak_count;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  serial_fifo dut (
    .clk                 (clk),
    .reset               (reset),
    .wr_data             (wr_data),
    .wr_request          (wr_request),
    .rd_request          (rd_request),
    .clear_flags_request (clear_flags_request),
    .afull_threshold     (afull_threshold),
    .aempty_threshold    (aempty_threshold),
    .rd_data             (rd_data),
    .empty               (empty),
    .full                (full),
    .almost_full         (almost_full),
    .almost_empty        (almost_empty),
    .overflow            (overflow),
    .underflow           (underflow),
    .wr_index            (wr_index),
    .rd_index            (rd_index),
    .count               (count),
    .peak_count          (peak_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_request          = 1'b0;
    rd_request          = 1'b0;
    clear_flags_request = 1'b0;
  endtask

  task automatic push(input logic [8:0] d);
    wr_data = d; wr_request = 1'b1; rd_request = 1'b0;
    step();
    idle();
  endtask

  task automatic pop();
    wr_request = 1'b0; rd_request = 1'b1;
    step();
    idle();
  endtask

  initial begin
    reset = 1'b0;
    wr_data = '0;
    idle();
    afull_threshold  = 5'd17;
    aempty_threshold = 5'd0;
    step(); step();

    // reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_peak", 32'(peak_count), 0);
    afull_threshold = 5'd0;
    #1 chk("rst_afull_thr0", 32'(almost_full), 1);
    afull_threshold = 5'd17;
    reset = 1'b1;

    // fill 16
    for (int i = 0; i < 16; i++) push(9'(9'h100 + i));
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_ovf", 32'(overflow), 0);
    chk("fill_wr_index", 32'(wr_index), 16);

    // drain 16 in order
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(rd_data), 32'(9'h100 + i));
      pop();
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_rd_index", 32'(rd_index), 16);

    // full with both requests
    for (int i = 0; i < 16; i++) push(9'(9'h100 + i));
    chk("refill_wr_index", 32'(wr_index), 0);
    wr_data = 9'h1FF; wr_request = 1'b1; rd_request = 1'b1;
    step(); idle();
    chk("fullboth_count", 32'(count), 15);
    chk("fullboth_ovf", 32'(overflow), 1);
    chk("fullboth_wr_index", 32'(wr_index), 0);
    chk("fullboth_rd_index", 32'(rd_index), 17);
    for (int i = 1; i < 16; i++) begin
      chk("fullboth_drain", 32'(rd_data), 32'(9'h100 + i));
      pop();
    end
    chk("fullboth_empty", 32'(empty), 1);
    chk("ovf_sticky", 32'(overflow), 1);

    // empty with both requests
    wr_data = 9'h055; wr_request = 1'b1; rd_request = 1'b1;
    step(); idle();
    chk("emptyboth_count", 32'(count), 1);
    chk("emptyboth_udf", 32'(underflow), 1);
    chk("emptyboth_data", 32'(rd_data), 32'h055);
    pop();
    chk("emptyboth_wr_index", 32'(wr_index), 1);
    chk("emptyboth_rd_index", 32'(rd_index), 1);

    // clear sticky flags and peak
    clear_flags_request = 1'b1;
    step(); idle();
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_udf", 32'(underflow), 0);
    chk("clr_peak", 32'(peak_count), 0);

    // wrap-around at steady count 3
    for (int i = 0; i < 3; i++) begin
      push(9'(9'h200 + i));
      exp_q.push_back(9'(9'h200 + i));
    end
    for (int i = 0; i < 40; i++) begin
      chk("wrap_data", 32'(rd_data), 32'(exp_q[0]));
      wr_data = 9'(9'h080 + i * 7);
      exp_q.push_back(wr_data);
      void'(exp_q.pop_front());
      wr_request = 1'b1; rd_request = 1'b1;
      step(); idle();
      chk("wrap_empty", 32'(empty), 0);
      chk("wrap_full", 32'(full), 0);
      chk("wrap_count", 32'(count), 3);
    end
    chk("wrap_wr_index", 32'(wr_index), 12);
    chk("wrap_rd_index", 32'(rd_index), 9);
    chk("wrap_peak", 32'(peak_count), 3);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_drain", 32'(rd_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      pop();
    end
    chk("wrap_end_empty", 32'(empty), 1);

    // thresholds, peak hold and clear
    afull_threshold  = 5'd12;
    aempty_threshold = 5'd2;
    pop();
    chk("thr_udf_set", 32'(underflow), 1);
    chk("thr_udf_rd_index", 32'(rd_index), 12);
    for (int i = 1; i <= 14; i++) begin
      push(9'(i));
      chk("ramp_up_afull", 32'(almost_full), (i >= 12) ? 1 : 0);
      chk("ramp_up_aempty", 32'(almost_empty), (i <= 2) ? 1 : 0);
    end
    chk("ramp_peak", 32'(peak_count), 14);
    for (int i = 13; i >= 5; i--) begin
      pop();
      chk("ramp_dn_afull", 32'(almost_full), (i >= 12) ? 1 : 0);
    end
    chk("ramp_peak_held", 32'(peak_count), 14);
    clear_flags_request = 1'b1;
    step(); idle();
    chk("clr5_peak", 32'(peak_count), 5);
    chk("clr5_udf", 32'(underflow), 0);
    chk("clr5_ovf", 32'(overflow), 0);
    for (int i = 4; i >= 0; i--) begin
      pop();
      chk("ramp_dn_aempty", 32'(almost_empty), (i <= 2) ? 1 : 0);
    end
    chk("ramp_end_empty", 32'(empty), 1);
    chk("ramp_end_peak", 32'(peak_count), 5);

    // mid-operation reset with a write in flight
    for (int i = 0; i < 9; i++) push(9'(9'h0C0 + i));
    chk("pre_rst_count", 32'(count), 9);
    wr_data = 9'h1EE; wr_request = 1'b1; reset = 1'b0;
    step(); idle();
    chk("mrst_count", 32'(count), 0);
    chk("mrst_wr_index", 32'(wr_index), 0);
    chk("mrst_rd_index", 32'(rd_index), 0);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_full", 32'(full), 0);
    chk("mrst_peak", 32'(peak_count), 0);
    chk("mrst_aempty", 32'(almost_empty), 1);
    chk("mrst_afull", 32'(almost_full), 0);
    reset = 1'b1;
    push(9'h0AB);
    chk("post_rst_wr_index", 32'(wr_index), 1);
    chk("post_rst_data", 32'(rd_data), 32'h0AB);
    chk("post_rst_count", 32'(count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_fifo.md
# serial_fifo

Parametrised synchronous FIFO for the serial IP and the next generation of its 16x9 TX/RX buffer. Data width and depth are parameters. Simultaneous read and write are both serviced in the same cycle. Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, a zero-lag fill count, and a peak-fill (high-water) register for the AXI status/register block.

## Interface
Parameters:
- DATA_WIDTH, 9, bits per entry
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-low
- wr_data  in  DATA_WIDTH  write data
- wr_request  in  1  push request (one entry per cycle while high)
- rd_request  in  1  pop request (one entry per cycle while high)
- clear_flags_request  in  1  clears overflow, underflow, peak_count
- afull_threshold  in  ADDR_WIDTH+1  almost_full when count ≥ this
- aempty_threshold  in  ADDR_WIDTH+1  almost_empty when count ≤ this
- rd_data  out  DATA_WIDTH  show-ahead: entry at rd_index, valid when !empty
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  combinational from count and afull_threshold
- almost_empty  out  1  combinational from count and aempty_threshold
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- wr_index  out  ADDR_WIDTH+1  write pointer, MSB is wrap bit
- rd_index  out  ADDR_WIDTH+1  read pointer, MSB is wrap bit
- count  out  ADDR_WIDTH+1  wr_index − rd_index, modulo 2**(ADDR_WIDTH+1)
- peak_count  out  ADDR_WIDTH+1  maximum count since reset/clear

## Operation
- Pointers are ADDR_WIDTH+1 bits and wrap naturally at 2**(ADDR_WIDTH+1). Storage is addressed by the low ADDR_WIDTH bits.
- empty = pointers equal. full = low bits equal and MSBs differ.
- Write accepted (wa) = wr_request & !full. On wa, store wr_data at wr_index and increment wr_index.
- Read accepted (ra) = rd_request & !empty. On ra, increment rd_index.
- wa and ra are independent; both may occur in one cycle. full and empty are evaluated on pre-edge state:
  - Full with both requests: the read proceeds, the write is rejected, overflow sets. Count becomes DEPTH−1.
  - Empty with both requests: the write proceeds, the read is rejected, underflow sets. Count becomes 1.
  - Neither full nor empty: count is unchanged.
- overflow sets on wr_request & full. underflow sets on rd_request & empty. Both hold until clear_flags_request or reset.
- If set and clear occur in the same cycle, set wins.
- count is combinational from the registered pointers, so it has zero lag relative to the pointers.
- peak_count next value:
  - If clear_flags_request: next count.
  - Otherwise: max(peak_count, next count).
- Thresholds are sampled combinationally and may change at any time. A threshold above DEPTH means almost_full never asserts. A threshold of 0 means almost_empty equals empty.
- Storage is not reset. rd_data is don't-care while empty.

## Timing
- Reset (reset==0 at a clock edge):
  - wr_index, rd_index, count, peak_count = 0
  - overflow = 0, underflow = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = (afull_threshold==0)
- Reset takes priority over every request in the same cycle. An in-flight write in the reset cycle is discarded.
- Write-to-read latency is 1 cycle: data written at edge N is on rd_data, with empty=0, after edge N.
- Pop: rd_data shows the next entry after the edge where ra occurred.
- Flags, count, and pointers update at the same edge as the accepted access. There is no extra register stage.
- Sustained throughput is one write plus one read per cycle.

## Structure
- Package serial_fifo_pkg:
  - Default DATA_WIDTH and ADDR_WIDTH localparams.
  - A status struct bundling the flags, count and peak_count, for the register block.
- Sub-module serial_fifo_ram: simple dual-port storage with a DEPTH x DATA_WIDTH array, synchronous write, and asynchronous read at the rd address. It has no reset and is infer-friendly for LUTRAM.
- Top level holds the pointers, flag logic, and peak tracker.

## Test plan
- Reset then fill: 16 writes of 0x100..0x10F (default params). Required: full=1 and count=16 after the 16th edge, overflow=0. Then drain 16 reads: rd_data sequence is 0x100..0x10F, then empty=1.
- Full with both requests: at count=16, assert wr_request and rd_request together. Required: count=15, overflow=1, wr_index unchanged, rd_index +1.
- Empty with both requests: at count=0, write 0x055 with a read. Required: count=1, underflow=1, rd_data=0x055 next cycle.
- Wrap-around: 40 interleaved write/read cycles at steady count=3. Required: pointers pass 31→0, data order is preserved, empty/full are never falsely asserted, peak_count=3.
- Thresholds and clear: set afull_threshold=12 and aempty_threshold=2, then ramp count 0→14→0.
  - almost_full asserts at count 12.
  - almost_empty asserts at count ≤2.
  - peak_count=14 is held.
  - Pulsing clear_flags_request at count 5 sets peak_count=5 and clears the sticky flags.
- Mid-operation reset: drop reset while count=9 and wr_request is high. Required: all outputs take their reset values at that edge, and the next write lands at index 0.
